mcu1: RTL and testbench

Parametrised multicycle accumulator microcontroller; successor to the single-cycle `mcu` core. It has an explicit fetch/decode/memory state machine, a single-port memory interface with a req/ack handshake, an asynchronous active-low reset and an extended opcode set. Program and data share one external word-addressed memory. The block sits between the testbench or SoC top and a memory model that may insert wait states.

---
 rtl/mcu1.sv | 188 ++++++++++++++++++
 tb/tb_mcu1.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu1.sv
// mcu1: multicycle accumulator MCU (FETCH/DECODE/MEM/HALT) with a registered req/ack memory port.
// Optional single-level CALL/RET with a link register is enabled by defining MCU1_CALL_EN.
module mcu1 #(
  parameter int            W        = 16,
  parameter int            AW       = 12,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata,
  input  logic          mem_ack,
  output logic          halted,
  output logic [AW-1:0] pc_o,
  output logic [W-1:0]  a_o,
  output logic [W-1:0]  sw_o
);

  localparam int            CW     = W - 4;
  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_FETCH, ST_DECODE, ST_MEM, ST_HALT} state_e;

  typedef enum logic [3:0] {
    OP_LD   = 4'h0, OP_ADD = 4'h1, OP_JMP = 4'h2, OP_ST   = 4'h3,
    OP_CMP  = 4'h4, OP_JEQ = 4'h5, OP_SUB = 4'h6, OP_JLT  = 4'h7,
    OP_AND  = 4'h8, OP_OR  = 4'h9, OP_XOR = 4'hA, OP_LDI  = 4'hB,
    OP_CALL = 4'hC, OP_RET = 4'hD, OP_NOP = 4'hE, OP_HALT = 4'hF
  } opcode_e;

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [AW-1:0] w_target;
  logic [W-1:0]  r_ir, w_ir_nxt;
  logic [W-1:0]  r_a, w_a_nxt;
  logic          r_n, w_n_nxt;
  logic          r_z, w_z_nxt;
  logic          r_req, w_req_nxt;
  logic          r_we, w_we_nxt;
`ifdef MCU1_CALL_EN
  logic [AW-1:0] r_lr, w_lr_nxt;
`endif

  opcode_e       w_op;
  logic [AW-1:0] w_c_addr;
  logic          w_is_mem;

  assign w_op     = opcode_e'(r_ir[W-1 -: 4]);
  assign w_c_addr = r_ir[AW-1:0];
  assign w_is_mem = w_op inside {OP_LD, OP_ADD, OP_ST, OP_CMP, OP_SUB, OP_AND, OP_OR, OP_XOR};

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_ir_nxt    = r_ir;
    w_a_nxt     = r_a;
    w_n_nxt     = r_n;
    w_z_nxt     = r_z;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_target    = r_pc;
`ifdef MCU1_CALL_EN
    w_lr_nxt    = r_lr;
`endif

    case (r_state)
      ST_FETCH: begin
        if (!r_req) begin
          // First cycle out of reset: launch the initial fetch.
          w_req_nxt  = 1'b1;
          w_we_nxt   = 1'b0;
          w_addr_nxt = r_pc;
        end else if (mem_ack) begin
          w_ir_nxt    = mem_rdata;
          w_pc_nxt    = r_pc + PC_ONE;
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (w_is_mem) begin
          w_state_nxt = ST_MEM;
          w_req_nxt   = 1'b1;
          w_we_nxt    = (w_op == OP_ST);
          w_addr_nxt  = w_c_addr;
        end else begin
          case (w_op)
            OP_JMP:  w_target = w_c_addr;
            OP_JEQ:  if (r_z) w_target = w_c_addr;
            OP_JLT:  if (r_n) w_target = w_c_addr;
            OP_LDI:  w_a_nxt = {4'b0000, r_ir[CW-1:0]};
`ifdef MCU1_CALL_EN
            OP_CALL: begin
              w_lr_nxt = r_pc;
              w_target = w_c_addr;
            end
            OP_RET:  w_target = r_lr;
`endif
            default: ;
          endcase
          w_pc_nxt = w_target;
          if (w_op == OP_HALT) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_state_nxt = ST_FETCH;
            w_req_nxt   = 1'b1;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = w_target;
          end
        end
      end

      ST_MEM: begin
        if (mem_ack) begin
          case (w_op)
            OP_LD:  w_a_nxt = mem_rdata;
            OP_ADD: w_a_nxt = r_a + mem_rdata;
            OP_SUB: w_a_nxt = r_a - mem_rdata;
            OP_AND: w_a_nxt = r_a & mem_rdata;
            OP_OR:  w_a_nxt = r_a | mem_rdata;
            OP_XOR: w_a_nxt = r_a ^ mem_rdata;
            OP_CMP: begin
              w_n_nxt = (r_a < mem_rdata);
              w_z_nxt = (r_a == mem_rdata);
            end
            default: ;
          endcase
          // Back-to-back: the next fetch is issued without dropping req.
          w_state_nxt = ST_FETCH;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = r_pc;
        end
      end

      ST_HALT: w_req_nxt = 1'b0;

      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_addr  <= '0;
      r_ir    <= '0;
      r_a     <= '0;
      r_n     <= 1'b0;
      r_z     <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
`ifdef MCU1_CALL_EN
      r_lr    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_ir    <= w_ir_nxt;
      r_a     <= w_a_nxt;
      r_n     <= w_n_nxt;
      r_z     <= w_z_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
`ifdef MCU1_CALL_EN
      r_lr    <= w_lr_nxt;
`endif
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_a;
  assign halted    = (r_state == ST_HALT);
  assign pc_o      = r_pc;
  assign a_o       = r_a;
  assign sw_o      = {r_n, r_z, {(W-2){1'b0}}};

endmodule

// File: tb/tb_mcu1.sv
// Self-checking bench for mcu1: ALU vector table, countdown loop with wait states,
// reset mid-store, CALL/RET (or NOP fall-through) and PC wrap.
module tb_mcu1;
  localparam int W  = 16;
  localparam int AW = 12;
  localparam int MW = 4096;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          mem_req, mem_we, mem_ack, halted;
  logic [AW-1:0] mem_addr, pc_o;
  logic [W-1:0]  mem_wdata, mem_rdata, a_o, sw_o;

  always #5 clock = ~clock;

  mcu1 #(.W(W), .AW(AW), .RESET_PC('0)) dut (
    .clock(clock), .reset_n(reset_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halted(halted), .pc_o(pc_o), .a_o(a_o), .sw_o(sw_o)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [W-1:0]  data;
  } acc_t;

  // Memory model with optional random wait states and a log of completed accesses.
  logic [W-1:0]  m [MW];
  logic          ld_en, clr, ack_hold, ack_force, wait_mode;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  int            wait_left;
  int            viol;
  acc_t          log_q[$];
  logic          p_pend, p_we;
  logic [AW-1:0] p_addr;
  logic [W-1:0]  p_wdata;

  assign mem_ack   = ack_force || (mem_req && !ack_hold && (wait_left == 0));
  assign mem_rdata = m[mem_addr];

  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < MW; i++) m[i] <= '0;
      log_q.delete();
      viol      <= 0;
      wait_left <= 0;
      p_pend    <= 1'b0;
    end else begin
      if (ld_en) m[ld_addr] <= ld_data;
      if (p_pend && mem_req && (mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata))
        viol <= viol + 1;
      p_pend  <= mem_req && !mem_ack;
      p_addr  <= mem_addr;
      p_we    <= mem_we;
      p_wdata <= mem_wdata;
      if (mem_req && mem_ack) begin
        if (mem_we) m[mem_addr] <= mem_wdata;
        log_q.push_back({mem_addr, mem_we, mem_we ? mem_wdata : mem_rdata});
        wait_left <= wait_mode ? int'($urandom_range(0, 4)) : 0;
      end else if (mem_req && wait_left > 0) begin
        wait_left <= wait_left - 1;
      end
    end
  end

  int   total = 0;
  int   passed = 0;
  acc_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic logic [W-1:0] ins(input logic [3:0] op, input logic [11:0] c);
    return {op, c};
  endfunction

  task automatic start_test();
    @(negedge clock);
    reset_n = 1'b0; clr = 1'b1; ack_hold = 1'b0; ack_force = 1'b0;
    @(negedge clock);
    clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  // Cycles are counted from the edge where mem_req first rises to the edge that sets halted.
  task automatic run(input int budget, output int cyc);
    bit started = 1'b0;
    cyc = 0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (started) cyc++;
      if (mem_req) started = 1'b1;
      if (halted) break;
    end
  endtask

  task automatic check_writes(input string tag);
    int   n = 0;
    acc_t e;
    foreach (log_q[i]) if (log_q[i].we) n++;
    check({tag, "_wr_count"}, n, exp_q.size());
    foreach (log_q[i]) begin
      if (log_q[i].we && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_wr"}, log_q[i], e);
      end
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [11:0] a0;
    logic [15:0] mval;
    logic [15:0] exp_a;
    logic [15:0] exp_sw;
  } vec_t;

  vec_t       vecs[11];
  int         cyc;
  logic [W-1:0] snap [64];

  initial begin
    int n_sub, n_jeq, diff;
    reset_n = 1'b1; clr = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    ack_hold = 1'b0; ack_force = 1'b0; wait_mode = 1'b0;
    #1 reset_n = 1'b0;

    vecs[0]  = '{4'h1, 12'h005, 16'h0003, 16'h0008, 16'h0000};
    vecs[1]  = '{4'h1, 12'hFFF, 16'hF001, 16'h0000, 16'h0000};
    vecs[2]  = '{4'h6, 12'h003, 16'h0005, 16'hFFFE, 16'h0000};
    vecs[3]  = '{4'h8, 12'hF0F, 16'h00FF, 16'h000F, 16'h0000};
    vecs[4]  = '{4'h9, 12'hF00, 16'h000F, 16'h0F0F, 16'h0000};
    vecs[5]  = '{4'hA, 12'hFFF, 16'hAAAA, 16'hA555, 16'h0000};
    vecs[6]  = '{4'h0, 12'h123, 16'hBEEF, 16'hBEEF, 16'h0000};
    vecs[7]  = '{4'h4, 12'h003, 16'h0005, 16'h0003, 16'h8000};
    vecs[8]  = '{4'h4, 12'h005, 16'h0005, 16'h0005, 16'h4000};
    vecs[9]  = '{4'h4, 12'h007, 16'h0005, 16'h0007, 16'h0000};
    vecs[10] = '{4'h4, 12'h000, 16'hFFFF, 16'h0000, 16'h8000};

    // Reset state
    start_test();
    #1;
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 12'h000);
    check("rst_halted", halted, 1'b0);
    check("rst_pc", pc_o, 12'h000);
    check("rst_a", a_o, 16'h0000);
    check("rst_sw", sw_o, 16'h0000);

    // ALU / CMP vectors: LDI a0; OP [0x40]; ST [0x41]; HALT
    for (int i = 0; i < 11; i++) begin
      start_test();
      load(12'h000, ins(4'hB, vecs[i].a0));
      load(12'h001, ins(vecs[i].op, 12'h040));
      load(12'h002, ins(4'h3, 12'h041));
      load(12'h003, ins(4'hF, 12'h000));
      load(12'h040, vecs[i].mval);
      exp_q.push_back({12'h041, 1'b1, vecs[i].exp_a});
      run(100, cyc);
      check($sformatf("vec%0d_halted", i), halted, 1'b1);
      check($sformatf("vec%0d_cycles", i), cyc, 10);
      check($sformatf("vec%0d_a", i), a_o, vecs[i].exp_a);
      check($sformatf("vec%0d_sw", i), sw_o, vecs[i].exp_sw);
      check($sformatf("vec%0d_req_off", i), mem_req, 1'b0);
      check_writes($sformatf("vec%0d", i));
    end

    // Countdown loop, zero-wait then random wait states
    for (int pass = 0; pass < 2; pass++) begin
      start_test();
      wait_mode = (pass == 1);
      load(12'h000, ins(4'hB, 12'h003));
      load(12'h001, ins(4'h6, 12'h030));
      load(12'h002, ins(4'h4, 12'h031));
      load(12'h003, ins(4'h5, 12'h006));
      load(12'h004, ins(4'h2, 12'h001));
      load(12'h005, ins(4'hE, 12'h000));
      load(12'h006, ins(4'h3, 12'h032));
      load(12'h007, ins(4'hF, 12'h000));
      load(12'h030, 16'h0001);
      load(12'h031, 16'h0000);
      load(12'h032, 16'h5A5A);
      exp_q.push_back({12'h032, 1'b1, 16'h0000});
      run(2000, cyc);
      n_sub = 0; n_jeq = 0;
      foreach (log_q[i]) begin
        if (!log_q[i].we && log_q[i].addr == 12'h001) n_sub++;
        if (!log_q[i].we && log_q[i].addr == 12'h006) n_jeq++;
      end
      check($sformatf("cd%0d_halted", pass), halted, 1'b1);
      check($sformatf("cd%0d_sub_iters", pass), n_sub, 3);
      check($sformatf("cd%0d_jeq_taken", pass), n_jeq, 1);
      check($sformatf("cd%0d_a", pass), a_o, 16'h0000);
      check($sformatf("cd%0d_sw", pass), sw_o, 16'h4000);
      check($sformatf("cd%0d_hs_stable", pass), viol, 0);
      check_writes($sformatf("cd%0d", pass));
      if (pass == 0) begin
        for (int i = 0; i < 64; i++) snap[i] = m[i];
      end else begin
        diff = 0;
        for (int i = 0; i < 64; i++) if (m[i] !== snap[i]) diff++;
        check("cd_mem_same", diff, 0);
      end
    end
    wait_mode = 1'b0;

    // JLT taken after CMP sets N
    start_test();
    load(12'h000, ins(4'hB, 12'h001));
    load(12'h001, ins(4'h4, 12'h040));
    load(12'h002, ins(4'h7, 12'h005));
    load(12'h003, ins(4'hB, 12'h033));
    load(12'h004, ins(4'hF, 12'h000));
    load(12'h005, ins(4'hB, 12'h055));
    load(12'h006, ins(4'hF, 12'h000));
    load(12'h040, 16'h0002);
    run(100, cyc);
    check("jlt_a", a_o, 16'h0055);
    check("jlt_sw", sw_o, 16'h8000);

    // Reset during a stalled ST; late ack after release must be ignored
    start_test();
    load(12'h000, ins(4'hB, 12'h007));
    load(12'h001, ins(4'h3, 12'h050));
    load(12'h002, ins(4'hF, 12'h000));
    load(12'h050, 16'hDEAD);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (mem_req && mem_we) break;
    end
    ack_hold = 1'b1;
    check("st_reached", mem_we, 1'b1);
    repeat (3) @(negedge clock);
    check("st_hold_req", mem_req, 1'b1);
    check("st_hold_addr", mem_addr, 12'h050);
    check("st_hold_data", mem_wdata, 16'h0007);
    #2 reset_n = 1'b0;
    #1;
    check("st_rst_req_drop", mem_req, 1'b0);
    check("st_rst_we_drop", mem_we, 1'b0);
    check("st_rst_a", a_o, 16'h0000);
    ack_hold = 1'b0;
    ack_force = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("late_ack_pc", pc_o, 12'h000);
    check("restart_req", mem_req, 1'b1);
    check("restart_addr", mem_addr, 12'h000);
    ack_force = 1'b0;
    check("st_no_write", m[12'h050], 16'hDEAD);
    check_writes("st_rst");

    // CALL/RET, or NOP fall-through when the link register is absent
    start_test();
    load(12'h000, ins(4'h2, 12'h005));
    load(12'h005, ins(4'hC, 12'h020));
    load(12'h020, ins(4'hD, 12'h000));
    load(12'h006, ins(4'hB, 12'h066));
    load(12'h007, ins(4'hF, 12'h000));
    run(100, cyc);
    check("call_halted", halted, 1'b1);
    check("call_a", a_o, 16'h0066);
    begin
`ifdef MCU1_CALL_EN
      logic [AW-1:0] seq [5] = '{12'h000, 12'h005, 12'h020, 12'h006, 12'h007};
`else
      logic [AW-1:0] seq [4] = '{12'h000, 12'h005, 12'h006, 12'h007};
`endif
      check("call_fetch_count", log_q.size(), $size(seq));
      for (int i = 0; i < $size(seq); i++)
        if (i < log_q.size()) check($sformatf("call_fetch%0d", i), log_q[i].addr, seq[i]);
    end

    // PC wrap: NOP at the top address falls through to 0
    start_test();
    load(12'h000, ins(4'h2, 12'hFFF));
    load(12'hFFF, ins(4'hE, 12'h000));
    run(12, cyc);
    check("wrap_not_halted", halted, 1'b0);
    check("wrap_log_len", (log_q.size() >= 3), 1'b1);
    if (log_q.size() >= 3) begin
      check("wrap_fetch1", log_q[1].addr, 12'hFFF);
      check("wrap_fetch2", log_q[2].addr, 12'h000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
